// File: rtl/mips_boot_mem.sv
// Byte-wide unified I/D memory for the 8-bit multicycle MIPS core, with a boot loader that streams an image in while the core is held in reset.
// Reads are combinational, with zero latency; writes take one edge. The loader sees ld_ready=1 only in LOAD and is never stalled there.
module mips_boot_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] writedata,
   input  logic              memread,
   input  logic              memwrite,
   output logic [DATA_W-1:0] memdata,
   output logic              cpu_reset,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic [ADDR_W:0]   ld_count,
   output logic              ld_ovf,
   output logic              running
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                ld_ready_q, ld_ready_d;
   logic                running_q, running_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [DATA_W-1:0]   mem_wd;
   logic                rd_unused;

   // Reads are continuous, so the core's read strobe carries no information here.
   assign rd_unused = memread;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      mem_we  = 1'b0;
      mem_wa  = ptr_q;
      mem_wd  = ld_data;
      case (state_q)
         IDLE: begin
            if (ld_start) begin
               state_d = LOAD;
               ptr_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            // A restart pulse wins over any byte presented in the same cycle.
            if (ld_start) begin
               ptr_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end else if (ld_valid) begin
               mem_we  = 1'b1;
               ptr_d   = ptr_q + 1'b1;
               if (count_q != (ADDR_W+1)'(DEPTH))
                  count_d = count_q + 1'b1;
               if (ld_last)
                  state_d = RUN;
               else if (ptr_q == {ADDR_W{1'b1}})
                  ovf_d = 1'b1;
            end
         end
         RUN: begin
            if (memwrite) begin
               mem_we = 1'b1;
               mem_wa = adr;
               mem_wd = writedata;
            end
            if (ld_start) begin
               state_d = LOAD;
               ptr_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      cpu_reset_d = (state_d != RUN);
      ld_ready_d  = (state_d == LOAD);
      running_d   = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         cpu_reset_q <= 1'b1;
         ld_ready_q  <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         cpu_reset_q <= cpu_reset_d;
         ld_ready_q  <= ld_ready_d;
         running_q   <= running_d;
      end
   end

   // The array has no reset so an image survives a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[mem_wa] <= mem_wd;
   end

   assign memdata   = mem_q[adr];
   assign cpu_reset = cpu_reset_q;
   assign ld_ready  = ld_ready_q;
   assign ld_count  = count_q;
   assign ld_ovf    = ovf_q;
   assign running   = running_q;

endmodule

// File: tb/tb_mips_boot_mem.sv
// Bench for mips_boot_mem: directed boot/overflow/reset scenarios followed by random traffic, all checked against a behavioural model.
module tb_mips_boot_mem;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] adr = '0, writedata = '0, ld_data = '0;
   logic       memread = 1'b1, memwrite = 1'b0;
   logic       ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [7:0] memdata;
   logic       cpu_reset, ld_ready, ld_ovf, running;
   logic [8:0] ld_count;

   mips_boot_mem #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
      .memread(memread), .memwrite(memwrite), .memdata(memdata),
      .cpu_reset(cpu_reset), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .ld_count(ld_count), .ld_ovf(ld_ovf), .running(running)
   );

   always #5 clk = ~clk;

   int nchecks = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0=idle, 1=loading, 2=running; n_acc counts accepted bytes without saturation.
   int         m_mode = 0;
   int         n_acc = 0;
   logic [7:0] m_mem [256];
   bit         known [256];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = 0;
         n_acc  = 0;
      end else begin
         if (m_mode == 0) begin
            if (ld_start) begin m_mode = 1; n_acc = 0; end
         end else if (m_mode == 1) begin
            if (ld_start) n_acc = 0;
            else if (ld_valid) begin
               m_mem[n_acc % 256] = ld_data;
               known[n_acc % 256] = 1'b1;
               n_acc++;
               if (ld_last) m_mode = 2;
            end
         end else begin
            if (memwrite) begin m_mem[adr] = writedata; known[adr] = 1'b1; end
            if (ld_start) begin m_mode = 1; n_acc = 0; end
         end
      end
   end

   function automatic logic [31:0] exp_count();
      return (n_acc > 256) ? 256 : n_acc;
   endfunction

   function automatic logic [31:0] exp_ovf();
      return ((n_acc > 256) || (n_acc == 256 && m_mode == 1)) ? 1 : 0;
   endfunction

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("cpu_reset", 32'(cpu_reset), (m_mode != 2) ? 1 : 0);
         chk("ld_ready", 32'(ld_ready), (m_mode == 1) ? 1 : 0);
         chk("running", 32'(running), (m_mode == 2) ? 1 : 0);
         chk("ld_count", 32'(ld_count), exp_count());
         chk("ld_ovf", 32'(ld_ovf), exp_ovf());
         if (known[adr]) chk("memdata", 32'(memdata), 32'(m_mem[adr]));
      end
   end

   task automatic drive(input bit st, input bit v, input logic [7:0] d, input bit last,
                        input bit mw, input logic [7:0] a, input logic [7:0] wd);
      @(negedge clk);
      ld_start = st; ld_valid = v; ld_data = d; ld_last = last;
      memwrite = mw; adr = a; writedata = wd;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #3;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      #3;
      chk("rst_cpu_reset", 32'(cpu_reset), 1);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_ld_count", 32'(ld_count), 0);
      chk("rst_ld_ovf", 32'(ld_ovf), 0);
      @(negedge clk);
      reset = 1'b0;

      // Boot a 4-byte image.
      drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 8'h80, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 8'h44, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 8'h00, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 8'h20, 1, 0, 8'h00, 8'h00);
      after_edge();
      chk("boot_count", 32'(ld_count), 4);
      chk("boot_running", 32'(running), 1);
      chk("boot_cpu_reset", 32'(cpu_reset), 0);
      drive(0, 0, 8'h00, 0, 0, 8'h00, 8'h00); #1 chk("img0", 32'(memdata), 32'h80);
      drive(0, 0, 8'h00, 0, 0, 8'h01, 8'h00); #1 chk("img1", 32'(memdata), 32'h44);
      drive(0, 0, 8'h00, 0, 0, 8'h02, 8'h00); #1 chk("img2", 32'(memdata), 32'h00);
      drive(0, 0, 8'h00, 0, 0, 8'h03, 8'h00); #1 chk("img3", 32'(memdata), 32'h20);

      // Core store in RUN, then ignored store in LOAD.
      drive(0, 0, 8'h00, 0, 1, 8'h10, 8'hA5);
      drive(0, 0, 8'h00, 0, 0, 8'h10, 8'h00); #1 chk("run_store", 32'(memdata), 32'hA5);
      drive(1, 0, 8'h00, 0, 0, 8'h10, 8'h00);
      drive(0, 0, 8'h00, 0, 1, 8'h10, 8'h5A);
      drive(0, 0, 8'h00, 0, 0, 8'h10, 8'h00); #1 chk("load_store_ignored", 32'(memdata), 32'hA5);

      // Gapped valid in LOAD.
      drive(0, 1, 8'h11, 0, 0, 8'h00, 8'h00);
      drive(0, 0, 8'hEE, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 8'h22, 0, 0, 8'h00, 8'h00);
      drive(0, 0, 8'hEE, 0, 0, 8'h00, 8'h00);
      drive(0, 1, 8'h33, 0, 0, 8'h00, 8'h00);
      drive(0, 0, 8'hEE, 0, 0, 8'h00, 8'h00);
      after_edge();
      chk("gap_count", 32'(ld_count), 3);
      chk("gap_ready", 32'(ld_ready), 1);
      drive(0, 0, 8'h00, 0, 0, 8'h01, 8'h00); #1 chk("gap_byte1", 32'(memdata), 32'h22);
      drive(0, 0, 8'h00, 0, 0, 8'h02, 8'h00); #1 chk("gap_byte2", 32'(memdata), 32'h33);
      drive(0, 1, 8'h44, 1, 0, 8'h00, 8'h00);

      // Restart from RUN, then a 257-byte image that wraps.
      drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      after_edge();
      chk("restart_cpu_reset", 32'(cpu_reset), 1);
      chk("restart_ready", 32'(ld_ready), 1);
      chk("restart_count", 32'(ld_count), 0);
      for (int k = 1; k <= 257; k++) begin
         drive(0, 1, 8'(k) ^ 8'h5C, (k == 257), 0, 8'h00, 8'h00);
         if (k == 256) begin
            after_edge();
            chk("wrap_ovf", 32'(ld_ovf), 1);
            chk("wrap_count", 32'(ld_count), 256);
         end
      end
      after_edge();
      chk("big_count", 32'(ld_count), 256);
      chk("big_running", 32'(running), 1);
      chk("big_ovf", 32'(ld_ovf), 1);
      drive(0, 0, 8'h00, 0, 0, 8'h00, 8'h00); #1 chk("big_addr0", 32'(memdata), 32'h5D);
      drive(0, 0, 8'h00, 0, 0, 8'hFF, 8'h00); #1 chk("big_addr255", 32'(memdata), 32'h5C);

      // One-byte reload from RUN clears the overflow flag.
      drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      after_edge();
      chk("reload_ovf_clr", 32'(ld_ovf), 0);
      drive(0, 1, 8'h77, 1, 0, 8'h00, 8'h00);
      after_edge();
      chk("reload_running", 32'(running), 1);
      chk("reload_count", 32'(ld_count), 1);

      // Reset in the middle of a load.
      drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      for (int k = 0; k < 5; k++) drive(0, 1, 8'hA0 + 8'(k), 0, 0, 8'h00, 8'h00);
      drive(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      reset = 1'b1;
      #1;
      chk("midrst_cpu_reset", 32'(cpu_reset), 1);
      chk("midrst_ready", 32'(ld_ready), 0);
      chk("midrst_count", 32'(ld_count), 0);
      for (int k = 0; k < 5; k++) begin
         adr = 8'(k);
         #1 chk("midrst_keep", 32'(memdata), 32'hA0 + k);
      end
      @(negedge clk);
      reset = 1'b0;

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom % 40) == 0, $urandom % 2, 8'($urandom), ($urandom % 20) == 0,
               ($urandom % 3) == 0, 8'($urandom), 8'($urandom));
         if (($urandom % 500) == 0) reset = 1'b1;
         else if (reset) reset = 1'b0;
      end
      drive(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      reset = 1'b0;
      after_edge();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule

// File: doc/mips_boot_mem.md
Name: mips_boot_mem

Overview:
- Byte-wide unified instruction/data memory that sits directly below the 8-bit multicycle MIPS core.
- Consumes the core's adr, writedata, memread and memwrite, and supplies memdata back to it.
- Contains a boot loader FSM that streams a program image in through a valid/ready byte port while holding the core in reset, then releases the core to run.
- The core's reset is driven from this block's cpu_reset.

Parameters:
- ADDR_W, 8, address width; the memory holds 2**ADDR_W bytes.
- DATA_W, 8, data width; fixed at 8 for the core.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- adr  input  ADDR_W  byte address from the core.
- writedata  input  DATA_W  store data from the core.
- memread  input  1  core read strobe; informational only, reads are continuous.
- memwrite  input  1  core write strobe.
- memdata  output  DATA_W  read data to the core.
- cpu_reset  output  1  reset to the core; high unless in RUN.
- ld_start  input  1  single-cycle pulse that begins a (re)load.
- ld_valid  input  1  loader byte valid.
- ld_data  input  DATA_W  loader byte.
- ld_last  input  1  marks the final byte of the image; qualified by ld_valid.
- ld_ready  output  1  loader may transfer.
- ld_count  output  ADDR_W+1  bytes accepted in the current load.
- ld_ovf  output  1  sticky flag: load wrapped past the top address.
- running  output  1  FSM is in RUN.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, load pointer=0, ld_count=0, ld_ovf=0.
  - cpu_reset=1, ld_ready=0, running=0.
  - The memory array is not cleared.
- Read path:
  - memdata = mem[adr], combinational, in every state. This gives zero-latency reads, as the multicycle core requires.
  - Reads during reset return the array contents.
- States:
  - IDLE: cpu_reset=1, ld_ready=0. ld_start -> LOAD.
  - LOAD: cpu_reset=1, ld_ready=1.
    - A transfer occurs when ld_valid&ld_ready at a clock edge.
    - On a transfer: mem[ptr]<=ld_data; ptr<=ptr+1 (mod 2**ADDR_W); ld_count<=ld_count+1.
    - A transfer with ld_last=1 -> RUN on the same edge.
    - ld_start in LOAD restarts the load: ptr=0, ld_count=0, ld_ovf=0, and any byte presented that cycle is dropped.
  - RUN: cpu_reset=0, running=1, ld_ready=0.
    - memwrite=1 at an edge -> mem[adr]<=writedata.
    - ld_valid is ignored.
    - ld_start -> LOAD with ptr=0, ld_count=0, ld_ovf=0; cpu_reset rises the cycle after the pulse.
- Entering LOAD from IDLE or RUN clears ptr, ld_count and ld_ovf on the same edge.
- Overflow:
  - If a non-last byte is written at ptr=2**ADDR_W-1, ptr wraps to 0 and ld_ovf<=1 (sticky until next LOAD entry or reset).
  - ld_count saturates at 2**ADDR_W.
  - Loading continues after the wrap.
- Write conflicts:
  - Core memwrite is ignored outside RUN, since the core is held in reset.
  - Loader writes occur only in LOAD, so there is never more than one writer per cycle.
- Timing:
  - cpu_reset deasserts on the edge that accepts the last byte. The core's first fetch sees the full image.
  - The first core write can occur no earlier than the following edge.
- Reset mid-load: returns to IDLE. Bytes already written remain in the array, and ld_count reads 0.

Test Plan:
- Reset, pulse ld_start, stream 4 bytes 0x80,0x44,0x00,0x20 with ld_last on the 4th, ld_valid held:
  - ld_count=4, running=1, cpu_reset=0 on the edge accepting 0x20.
  - adr=0..3 reads back the four bytes.
- In RUN, drive memwrite=1, adr=0x10, writedata=0xA5 for one cycle:
  - memdata at adr=0x10 = 0xA5 the next cycle.
  - In LOAD, the same stimulus leaves mem[0x10] unchanged.
- In LOAD, toggle ld_valid 1/0/1 with 3 bytes:
  - Only qualified bytes are written, at consecutive addresses 0,1,2.
  - ld_count=3; ld_ready stays 1.
- Load 257 bytes with ld_last on the 257th:
  - ld_ovf=1 after byte 256; byte 257 lands at address 0.
  - ld_count=256 (saturated); running=1.
- Assert reset while in LOAD after 5 bytes:
  - State returns to IDLE immediately; cpu_reset=1, ld_ready=0, ld_count=0.
  - mem[0..4] still hold the loaded bytes.
- In RUN, pulse ld_start:
  - cpu_reset=1 next cycle, ld_ready=1, ld_count=0, ld_ovf cleared.
  - A 1-byte load with ld_last returns to RUN.
